// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decodes IF/ID and carries control words through ID/EX, EX/MEM and MEM/WB.
// Detects load-use and branch hazards. Define PIPE_CTRL_FORWARD_EN to enable operand forwarding.
module pipe_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        if_id_inst,
    input  logic               ex_mem_zero,
    output logic               stall,
    output logic               flush,
    output logic               id_sign_ext,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_use_imm,
    output logic               ex_shift,
    output logic               ex_dst_rd,
    output logic [1:0]         ex_fwd_a,
    output logic [1:0]         ex_fwd_b,
    output logic               mem_write,
    output logic               mem_branch_taken,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [REG_AW-1:0]  wb_dst,
    output logic               id_illegal
);

    // ALU_* codes shared with the datapath ALU
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(8);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               use_imm;
        logic               shift;
        logic               dst_rd;
        logic               mem_write;
        logic               mem_read;
        logic               branch;
        logic               reg_write;
        logic               mem_to_reg;
        logic [REG_AW-1:0]  dst;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic               reads_rs;
        logic               reads_rt;
    } ctrl_t;

    localparam ctrl_t NOP = '{alu_op: ALU_ADD, default: '0};

    ctrl_t idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d;
    ctrl_t dec;
    logic  illegal, sign_ext, hazard;
    logic  [5:0] opcode, funct;

    assign opcode = if_id_inst[31:26];
    assign funct  = if_id_inst[5:0];

    always_comb begin
        dec      = NOP;
        illegal  = 1'b0;
        sign_ext = 1'b1;
        case (opcode)
            6'h00: begin
                dec.dst_rd    = 1'b1;
                dec.reg_write = 1'b1;
                dec.reads_rs  = 1'b1;
                dec.reads_rt  = 1'b1;
                dec.dst       = REG_AW'(if_id_inst[15:11]);
                case (funct)
                    6'h20: dec.alu_op = ALU_ADD;
                    6'h22: dec.alu_op = ALU_SUB;
                    6'h24: dec.alu_op = ALU_AND;
                    6'h25: dec.alu_op = ALU_OR;
                    6'h27: dec.alu_op = ALU_NOR;
                    6'h2A: dec.alu_op = ALU_SLT;
                    6'h00: begin dec.alu_op = ALU_SLL; dec.shift = 1'b1; dec.reads_rs = 1'b0; end
                    6'h02: begin dec.alu_op = ALU_SRL; dec.shift = 1'b1; dec.reads_rs = 1'b0; end
                    6'h03: begin dec.alu_op = ALU_SRA; dec.shift = 1'b1; dec.reads_rs = 1'b0; end
                    default: illegal = 1'b1;
                endcase
            end
            6'h08, 6'h0C, 6'h0D, 6'h23: begin
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                dec.reads_rs  = 1'b1;
                dec.dst       = REG_AW'(if_id_inst[20:16]);
                if (opcode == 6'h0C) begin dec.alu_op = ALU_AND; sign_ext = 1'b0; end
                if (opcode == 6'h0D) begin dec.alu_op = ALU_OR;  sign_ext = 1'b0; end
                if (opcode == 6'h23) begin dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; end
            end
            6'h2B: begin
                dec.use_imm   = 1'b1;
                dec.mem_write = 1'b1;
                dec.reads_rs  = 1'b1;
                dec.reads_rt  = 1'b1;
            end
            6'h04: begin
                dec.alu_op   = ALU_SUB;
                dec.branch   = 1'b1;
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec = NOP;
        end else begin
            dec.rs = REG_AW'(if_id_inst[25:21]);
            dec.rt = REG_AW'(if_id_inst[20:16]);
            if (dec.dst == '0) dec.reg_write = 1'b0;
        end
    end

`ifdef PIPE_CTRL_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input ctrl_t em, input ctrl_t mw);
        if (src == '0)                                     fwd_sel = 2'b00;
        else if (em.reg_write && em.dst == src && !em.mem_read) fwd_sel = 2'b10;
        else if (mw.reg_write && mw.dst == src)            fwd_sel = 2'b01;
        else                                               fwd_sel = 2'b00;
    endfunction

    assign hazard = idex_q.mem_read && (idex_q.dst != '0) &&
                    ((dec.reads_rs && dec.rs == idex_q.dst) || (dec.reads_rt && dec.rt == idex_q.dst));
    assign ex_fwd_a = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    assign ex_fwd_b = fwd_sel(idex_q.rt, exmem_q, memwb_q);
`else
    // MEM/WB writes land in the first half-cycle, so only ID/EX and EX/MEM can conflict
    function automatic logic raw(input ctrl_t p, input ctrl_t id);
        raw = p.reg_write &&
              ((id.reads_rs && id.rs != '0 && id.rs == p.dst) ||
               (id.reads_rt && id.rt != '0 && id.rt == p.dst));
    endfunction

    assign hazard   = raw(idex_q, dec) || raw(exmem_q, dec);
    assign ex_fwd_a = 2'b00;
    assign ex_fwd_b = 2'b00;
`endif

    assign flush = exmem_q.branch & ex_mem_zero;
    assign stall = hazard & ~flush;

    always_comb begin
        idex_d  = (flush || stall) ? NOP : dec;
        exmem_d = flush ? NOP : idex_q;
        memwb_d = exmem_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q  <= NOP;
            exmem_q <= NOP;
            memwb_q <= NOP;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign id_sign_ext      = sign_ext;
    assign id_illegal       = illegal;
    assign ex_alu_op        = idex_q.alu_op;
    assign ex_use_imm       = idex_q.use_imm;
    assign ex_shift         = idex_q.shift;
    assign ex_dst_rd        = idex_q.dst_rd;
    assign mem_write        = exmem_q.mem_write;
    assign mem_branch_taken = flush;
    assign wb_reg_write     = memwb_q.reg_write;
    assign wb_mem_to_reg    = memwb_q.mem_to_reg;
    assign wb_dst           = memwb_q.dst;

    logic unused_bits;
    assign unused_bits = ^{if_id_inst[10:6], idex_q, exmem_q, memwb_q};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed hazard scenarios plus random instruction streams
// checked against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3, A_NOR = 4'd4,
                           A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8;
    localparam logic [31:0] BUBBLE = 32'hFFFF_FFFF;

    localparam logic [31:0] I_ADD8   = 32'h012A4020; // add $8,$9,$10
    localparam logic [31:0] I_SUB11  = 32'h01095822; // sub $11,$8,$9
    localparam logic [31:0] I_LW8    = 32'h8D280000; // lw  $8,0($9)
    localparam logic [31:0] I_ADD10  = 32'h01085020; // add $10,$8,$8
    localparam logic [31:0] I_BEQ    = 32'h10210004; // beq $1,$1,4
    localparam logic [31:0] I_SW8    = 32'hAD280000; // sw  $8,0($9)
    localparam logic [31:0] I_ILL    = 32'hFC000000; // opcode 0x3F
    localparam logic [31:0] I_ADD0   = 32'h012A0020; // add $0,$9,$10

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_id_inst;
    logic        ex_mem_zero;
    logic        stall, flush, id_sign_ext, ex_use_imm, ex_shift, ex_dst_rd;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic        mem_write, mem_branch_taken, wb_reg_write, wb_mem_to_reg, id_illegal;
    logic [4:0]  wb_dst;

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4)) dut (
        .clock(clock), .reset(reset), .if_id_inst(if_id_inst), .ex_mem_zero(ex_mem_zero),
        .stall(stall), .flush(flush), .id_sign_ext(id_sign_ext), .ex_alu_op(ex_alu_op),
        .ex_use_imm(ex_use_imm), .ex_shift(ex_shift), .ex_dst_rd(ex_dst_rd),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_write(mem_write),
        .mem_branch_taken(mem_branch_taken), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst), .id_illegal(id_illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic legal, rrs, rrt, wr, load, store, br, imm, sh, rdst, sx;
        logic [4:0] rs, rt, dst;
        logic [3:0] alu;
    } info_t;

    // Instruction semantics straight from the ISA subset: what each instruction reads, writes, does
    function automatic info_t info(input logic [31:0] w);
        info_t i;
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        i = '0;
        i.alu = A_ADD;
        i.sx  = 1'b1;
        if (op == 6'h00) begin
            i.legal = 1'b1;
            case (fn)
                6'h20: i.alu = A_ADD;
                6'h22: i.alu = A_SUB;
                6'h24: i.alu = A_AND;
                6'h25: i.alu = A_OR;
                6'h27: i.alu = A_NOR;
                6'h2A: i.alu = A_SLT;
                6'h00: begin i.alu = A_SLL; i.sh = 1'b1; end
                6'h02: begin i.alu = A_SRL; i.sh = 1'b1; end
                6'h03: begin i.alu = A_SRA; i.sh = 1'b1; end
                default: i.legal = 1'b0;
            endcase
            if (i.legal) begin
                i.rdst = 1'b1; i.rrt = 1'b1; i.rrs = !i.sh; i.dst = w[15:11];
            end else begin
                i.alu = A_ADD; i.sh = 1'b0;
            end
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h23) begin
            i.legal = 1'b1; i.imm = 1'b1; i.rrs = 1'b1; i.dst = w[20:16];
            if (op == 6'h0C) begin i.alu = A_AND; i.sx = 1'b0; end
            if (op == 6'h0D) begin i.alu = A_OR;  i.sx = 1'b0; end
            i.load = (op == 6'h23);
        end else if (op == 6'h2B) begin
            i.legal = 1'b1; i.imm = 1'b1; i.rrs = 1'b1; i.rrt = 1'b1; i.store = 1'b1;
        end else if (op == 6'h04) begin
            i.legal = 1'b1; i.rrs = 1'b1; i.rrt = 1'b1; i.br = 1'b1; i.alu = A_SUB;
        end
        if (i.legal) begin
            i.rs = w[25:21];
            i.rt = w[20:16];
            i.wr = (i.dst != 5'd0) && !i.store && !i.br;
        end
        return i;
    endfunction

    int checks = 0;
    int failures = 0;
    logic [31:0] ex_w = BUBBLE, mem_w = BUBBLE, wb_w = BUBBLE;
    logic exp_stall, exp_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] src, input info_t m, input info_t w);
`ifdef PIPE_CTRL_FORWARD_EN
        if (src == 5'd0) return 2'b00;
        if (m.wr && m.dst == src && !m.load) return 2'b10;
        if (w.wr && w.dst == src) return 2'b01;
        return 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    function automatic logic reads(input info_t id, input logic [4:0] r);
        return (r != 5'd0) && ((id.rrs && id.rs == r) || (id.rrt && id.rt == r));
    endfunction

    task automatic check_all(input string tag);
        info_t id, e, m, w;
        logic hz;
        id = info(if_id_inst); e = info(ex_w); m = info(mem_w); w = info(wb_w);
`ifdef PIPE_CTRL_FORWARD_EN
        hz = e.load && reads(id, e.dst);
`else
        hz = (e.wr && reads(id, e.dst)) || (m.wr && reads(id, m.dst));
`endif
        exp_flush = m.br && ex_mem_zero;
        exp_stall = hz && !exp_flush;
        chk({tag, ":stall"},   {31'd0, stall}, {31'd0, exp_stall});
        chk({tag, ":flush"},   {31'd0, flush}, {31'd0, exp_flush});
        chk({tag, ":taken"},   {31'd0, mem_branch_taken}, {31'd0, exp_flush});
        chk({tag, ":illegal"}, {31'd0, id_illegal}, {31'd0, !id.legal});
        chk({tag, ":sx"},      {31'd0, id_sign_ext}, {31'd0, id.sx});
        chk({tag, ":alu"},     {28'd0, ex_alu_op}, {28'd0, e.alu});
        chk({tag, ":ex_flags"}, {29'd0, ex_use_imm, ex_shift, ex_dst_rd}, {29'd0, e.imm, e.sh, e.rdst});
        chk({tag, ":fwd_a"},   {30'd0, ex_fwd_a}, {30'd0, fwd(e.rs, m, w)});
        chk({tag, ":fwd_b"},   {30'd0, ex_fwd_b}, {30'd0, fwd(e.rt, m, w)});
        chk({tag, ":mem_wr"},  {31'd0, mem_write}, {31'd0, m.store});
        chk({tag, ":wb"},      {25'd0, wb_reg_write, wb_mem_to_reg, wb_dst}, {25'd0, w.wr, w.load, w.dst});
    endtask

    // Advance the model on the rising edge, then drive the next ID instruction and check mid-cycle
    task automatic step(input logic [31:0] inst, input logic z, input string tag);
        @(posedge clock);
        if (reset) begin
            if (exp_flush) begin
                wb_w = mem_w; mem_w = BUBBLE; ex_w = BUBBLE;
            end else if (exp_stall) begin
                wb_w = mem_w; mem_w = ex_w; ex_w = BUBBLE;
            end else begin
                wb_w = mem_w; mem_w = ex_w; ex_w = if_id_inst;
            end
        end
        @(negedge clock);
        if_id_inst  = inst;
        ex_mem_zero = z;
        #1;
        check_all(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(32'h0, 1'b0, "drain");
    endtask

    logic [31:0] cur;

    function automatic logic [31:0] rnd_inst();
        logic [4:0] a, b, c;
        logic [5:0] fns [9];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
        a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 8))
            0, 1: return {6'h00, a, b, c, 5'd2, fns[$urandom_range(0, 8)]};
            2: return {6'h08, a, b, 16'h8001};
            3: return {($urandom_range(0, 1) == 0) ? 6'h0C : 6'h0D, a, b, 16'h00FF};
            4, 5: return {6'h23, a, b, 16'h0004};
            6: return {6'h2B, a, b, 16'h0008};
            7: return {6'h04, a, b, 16'h0002};
            default: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'h0} : {6'h00, a, b, c, 5'd0, 6'h3F};
        endcase
    endfunction

    initial begin
        reset = 1'b0; if_id_inst = I_ADD8; ex_mem_zero = 1'b0;
        #12;
        check_all("reset");
        chk("reset_alu", {28'd0, ex_alu_op}, {28'd0, A_ADD});
        @(negedge clock);
        reset = 1'b1;
        if_id_inst = 32'h0;
        #1;
        check_all("release");

        // add then dependent sub
        drain();
        step(I_ADD8, 1'b0, "a_add");
        step(I_SUB11, 1'b0, "a_sub");
`ifdef PIPE_CTRL_FORWARD_EN
        chk("a_nostall", {31'd0, stall}, 32'd0);
        step(32'h0, 1'b0, "a_ex");
        chk("a_fwd_a", {30'd0, ex_fwd_a}, 32'd2);
        chk("a_fwd_b", {30'd0, ex_fwd_b}, 32'd0);
`else
        chk("a_stall1", {31'd0, stall}, 32'd1);
        step(I_SUB11, 1'b0, "a_sub2");
        chk("a_stall2", {31'd0, stall}, 32'd1);
        step(I_SUB11, 1'b0, "a_sub3");
        chk("a_stall3", {31'd0, stall}, 32'd0);
        step(32'h0, 1'b0, "a_ex");
`endif

        // load-use
        drain();
        step(I_LW8, 1'b0, "b_lw");
        step(I_ADD10, 1'b0, "b_add");
        chk("b_stall", {31'd0, stall}, 32'd1);
        step(I_ADD10, 1'b0, "b_add2");
`ifdef PIPE_CTRL_FORWARD_EN
        chk("b_stall_end", {31'd0, stall}, 32'd0);
        chk("b_bubble", {29'd0, ex_use_imm, ex_shift, ex_dst_rd}, 32'd0);
        step(32'h0, 1'b0, "b_ex");
        chk("b_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 32'h5);
`else
        chk("b_stall2", {31'd0, stall}, 32'd1);
        step(I_ADD10, 1'b0, "b_add3");
        chk("b_stall_end", {31'd0, stall}, 32'd0);
        step(32'h0, 1'b0, "b_ex");
`endif

        // taken branch squashes sw (ID/EX) and add (ID)
        drain();
        step(I_BEQ, 1'b0, "c_beq");
        step(I_SW8, 1'b0, "c_sw");
        step(I_ADD8, 1'b1, "c_take");
        chk("c_flush", {30'd0, flush, mem_branch_taken}, 32'd3);
        step(32'h0, 1'b0, "c_p1");
        chk("c_flush_end", {31'd0, flush}, 32'd0);
        chk("c_no_sw", {31'd0, mem_write}, 32'd0);
        step(32'h0, 1'b0, "c_p2");
        chk("c_no_sw2", {31'd0, mem_write}, 32'd0);
        chk("c_no_wb", {31'd0, wb_reg_write}, 32'd0);
        step(32'h0, 1'b0, "c_p3");
        chk("c_no_wb2", {31'd0, wb_reg_write}, 32'd0);

        // flush and load-use together
        drain();
        step(I_BEQ, 1'b0, "d_beq");
        step(I_LW8, 1'b0, "d_lw");
        step(I_ADD10, 1'b1, "d_both");
        chk("d_stall", {31'd0, stall}, 32'd0);
        chk("d_flush", {31'd0, flush}, 32'd1);

        // illegal opcode and write to $0
        drain();
        step(I_ILL, 1'b0, "e_ill");
        chk("e_illegal", {31'd0, id_illegal}, 32'd1);
        step(I_ADD0, 1'b0, "e_add0");
        chk("e_legal", {31'd0, id_illegal}, 32'd0);
        step(32'h0, 1'b0, "e_p1");
        step(32'h0, 1'b0, "e_p2");
        chk("e_wb_ill", {31'd0, wb_reg_write}, 32'd0);
        step(32'h0, 1'b0, "e_p3");
        chk("e_wb_add0", {31'd0, wb_reg_write}, 32'd0);

        // reset asserted mid-stream
        for (int i = 0; i < 4; i++) step(I_ADD8, 1'b0, "f_fill");
        reset = 1'b0;
        #1;
        ex_w = BUBBLE; mem_w = BUBBLE; wb_w = BUBBLE;
        chk("f_wb", {31'd0, wb_reg_write}, 32'd0);
        chk("f_alu", {28'd0, ex_alu_op}, {28'd0, A_ADD});
        chk("f_sf", {30'd0, stall, flush}, 32'd0);
        check_all("f_rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_all("f_rel");
        step(32'h0, 1'b0, "f_resume");
        chk("f_ex_add", {31'd0, ex_dst_rd}, 32'd1);

        // random streams, IF/ID held while stalled
        cur = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!exp_stall) cur = rnd_inst();
            step(cur, 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
